// File: rtl/bit_array_pkg.sv
// Shared types and constants for the bit-array controller: FSM states,
// requester indices and the default array depth.
package bit_array_pkg;

    localparam int DEFAULT_DEPTH = 1048576;
    localparam int REQ_A         = 0;
    localparam int REQ_B         = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/bit_array_mem.sv
// 1-bit wide storage array: one write port and one registered read port.
// Contents are not reset; the controller zero-fills them after reset.
module bit_array_mem #(
    parameter int DEPTH = 1048576,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic          rdata
);

    logic mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bit_array_ctrl.sv
// Two-requester round-robin front end for a 1-bit array with a full zero-fill
// on reset or clear_req. Grant counters are built when BIT_ARRAY_CTRL_STATS_EN is defined.
module bit_array_ctrl
    import bit_array_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [1:0]    req_we,
    input  logic [AW-1:0] req_addr_a,
    input  logic [AW-1:0] req_addr_b,
    input  logic [1:0]    req_wdata,
    output logic [1:0]    rsp_valid,
    output logic          rsp_data,
    input  logic          clear_req,
    output logic          busy,
`ifdef BIT_ARRAY_CTRL_STATS_EN
    output logic [31:0]   stat_grants_a,
    output logic [31:0]   stat_grants_b,
`endif
    output state_t        dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid[i] && req_ready[i];
    // req_ready never depends on anything but req_valid, state and the pointer.
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic          PTR_A     = 1'(REQ_A);

    state_t        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          ptr_q, ptr_d;
    logic [1:0]    rsp_valid_q, rsp_valid_d;
    logic [1:0]    grant;
    logic          gnt_idx;
    logic [AW-1:0] gnt_addr;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic          mem_wdata;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic          mem_rdata;

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        ptr_d       = ptr_q;
        rsp_valid_d = 2'b00;
        grant       = 2'b00;
        gnt_idx     = 1'b0;
        gnt_addr    = '0;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = 1'b0;
        mem_re      = 1'b0;
        mem_raddr   = '0;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                if (clr_ptr_q == LAST_ADDR) begin
                    clr_ptr_d = '0;
                    state_d   = SERVE;
                end else begin
                    clr_ptr_d = clr_ptr_q + AW'(1);
                end
            end
            SERVE: begin
                if (req_valid[REQ_A] && (!req_valid[REQ_B] || ptr_q == PTR_A)) begin
                    grant[REQ_A] = 1'b1;
                end else if (req_valid[REQ_B]) begin
                    grant[REQ_B] = 1'b1;
                end
                if (grant != 2'b00) begin
                    gnt_idx  = grant[REQ_B];
                    gnt_addr = gnt_idx ? req_addr_b : req_addr_a;
                    ptr_d    = ~gnt_idx;
                    if (req_we[gnt_idx]) begin
                        mem_we    = 1'b1;
                        mem_waddr = gnt_addr;
                        mem_wdata = req_wdata[gnt_idx];
                    end else begin
                        mem_re      = 1'b1;
                        mem_raddr   = gnt_addr;
                        rsp_valid_d = grant;
                    end
                end
                // This cycle's grant still completes; the fill starts next cycle.
                if (clear_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_ptr_q   <= '0;
            ptr_q       <= PTR_A;
            rsp_valid_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    bit_array_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .re   (mem_re),
        .raddr(mem_raddr),
        .rdata(mem_rdata)
    );

    assign req_ready = grant;
    assign busy      = (state_q == CLEAR);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = (rsp_valid_q != 2'b00) ? mem_rdata : 1'b0;
    assign dbg_state = state_q;

`ifdef BIT_ARRAY_CTRL_STATS_EN
    logic [31:0] cnt_a_q, cnt_b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            if (grant[REQ_A] && cnt_a_q != '1) begin
                cnt_a_q <= cnt_a_q + 32'd1;
            end
            if (grant[REQ_B] && cnt_b_q != '1) begin
                cnt_b_q <= cnt_b_q + 32'd1;
            end
        end
    end

    assign stat_grants_a = cnt_a_q;
    assign stat_grants_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_bit_array_ctrl.sv
// Randomized and directed bench for bit_array_ctrl (DEPTH = 16) against a
// behavioural model; stat counters are checked when BIT_ARRAY_CTRL_STATS_EN is defined.
module tb_bit_array_ctrl;
    import bit_array_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    logic [1:0]    req_we = '0;
    logic [AW-1:0] req_addr_a = '0;
    logic [AW-1:0] req_addr_b = '0;
    logic [1:0]    req_wdata = '0;
    logic [1:0]    rsp_valid;
    logic          rsp_data;
    logic          clear_req = 1'b0;
    logic          busy;
    state_t        dbg_state;
`ifdef BIT_ARRAY_CTRL_STATS_EN
    logic [31:0]   stat_grants_a;
    logic [31:0]   stat_grants_b;
`endif

    always #5 clk = ~clk;

    bit_array_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr_a(req_addr_a),
        .req_addr_b(req_addr_b),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .clear_req (clear_req),
        .busy      (busy),
`ifdef BIT_ARRAY_CTRL_STATS_EN
        .stat_grants_a(stat_grants_a),
        .stat_grants_b(stat_grants_b),
`endif
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: array contents, cycles of fill left, preferred requester,
    // expected responses {requester, data}, and grant totals.
    bit          m_mem [DEPTH];
    int          m_busy_left;
    int          m_pref;
    logic [1:0]  exp_q[$];
    int unsigned m_ga, m_gb;

    logic        obs_busy;
    logic [1:0]  obs_ready;
    logic [1:0]  obs_rsp_valid;
    logic        obs_rsp_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 1'b0;
        m_busy_left = DEPTH;
        m_pref      = REQ_A;
        exp_q.delete();
        m_ga = 0;
        m_gb = 0;
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic cycle(input logic [1:0] v, input logic [1:0] we, input logic [AW-1:0] aa,
                         input logic [AW-1:0] ab, input logic [1:0] wd, input logic clr,
                         input logic r);
        logic [1:0] eg;
        logic [1:0] erv;
        logic       erd;
        logic [1:0] ent;
        int         g;
        int         addr;
        bit         was_busy;
        req_valid  = v;
        req_we     = we;
        req_addr_a = aa;
        req_addr_b = ab;
        req_wdata  = wd;
        clear_req  = clr;
        rst        = r;
        @(negedge clk);
        was_busy = (m_busy_left > 0);
        eg = 2'b00;
        g  = -1;
        if (!was_busy) begin
            if (v == 2'b11) g = m_pref;
            else if (v[0]) g = 0;
            else if (v[1]) g = 1;
            if (g >= 0) eg[g] = 1'b1;
        end
        erv = 2'b00;
        erd = 1'b0;
        if (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            erv[ent[1]] = 1'b1;
            erd = ent[0];
        end
        obs_busy      = busy;
        obs_ready     = req_ready;
        obs_rsp_valid = rsp_valid;
        obs_rsp_data  = rsp_data;
        check("busy", 32'(busy), 32'(was_busy));
        check("req_ready", 32'(req_ready), 32'(eg));
        check("rsp_valid", 32'(rsp_valid), 32'(erv));
        check("rsp_data", 32'(rsp_data), 32'(erd));
`ifdef BIT_ARRAY_CTRL_STATS_EN
        check("stat_a_track", stat_grants_a, m_ga);
        check("stat_b_track", stat_grants_b, m_gb);
`endif
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (m_busy_left > 0) m_busy_left--;
            if (g >= 0) begin
                addr = (g == 1) ? int'(ab) : int'(aa);
                if (g == 0 && m_ga != 32'hFFFF_FFFF) m_ga++;
                if (g == 1 && m_gb != 32'hFFFF_FFFF) m_gb++;
                if (we[g]) m_mem[addr] = wd[g];
                else exp_q.push_back({1'(g), m_mem[addr]});
                m_pref = 1 - g;
            end
            if (clr && !was_busy) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 1'b0;
                m_busy_left = DEPTH;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'b00, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
    endtask

    // Idle for a fixed window and count the cycles busy was seen high.
    task automatic count_fill(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(2'b00, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
            if (obs_busy) n++;
        end
    endtask

    int nfill;

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Fill after reset lasts DEPTH cycles, then every address reads 0.
        count_fill(nfill);
        check("reset_fill_len", 32'(nfill), 32'd16);
        for (int i = 0; i < DEPTH; i++) cycle(2'b01, 2'b00, AW'(i), '0, 2'b00, 1'b0, 1'b0);
        cycle(2'b10, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
        idle(1);

        // Both requesters continuously reading addr 3: A,B,A,B...
        for (int i = 0; i < 6; i++) begin
            cycle(2'b11, 2'b00, AW'(3), AW'(3), 2'b00, 1'b0, 1'b0);
            check("alternate", 32'(obs_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        idle(1);

        // A writes 1 to addr 5, B reads it on the next cycle.
        cycle(2'b01, 2'b01, AW'(5), '0, 2'b01, 1'b0, 1'b0);
        cycle(2'b10, 2'b00, '0, AW'(5), 2'b00, 1'b0, 1'b0);
        idle(1);
        check("raw_rsp_valid", 32'(obs_rsp_valid), 32'd2);
        check("raw_rsp_data", 32'(obs_rsp_data), 32'd1);

        // Clear coinciding with an A read of a 1-valued address.
        cycle(2'b01, 2'b00, AW'(5), '0, 2'b00, 1'b1, 1'b0);
        cycle(2'b00, 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
        check("clr_rsp_valid", 32'(obs_rsp_valid), 32'd1);
        check("clr_rsp_data", 32'(obs_rsp_data), 32'd1);
        count_fill(nfill);
        check("clear_fill_len", 32'(nfill), 32'd15);
        cycle(2'b01, 2'b00, AW'(5), '0, 2'b00, 1'b0, 1'b0);
        idle(1);
        check("after_clear_data", 32'(obs_rsp_data), 32'd0);

        // Reset at fill cycle 7 restarts the fill.
        cycle(2'b00, 2'b00, '0, '0, 2'b00, 1'b1, 1'b0);
        idle(7);
        cycle(2'b00, 2'b00, '0, '0, 2'b00, 1'b0, 1'b1);
        count_fill(nfill);
        check("rst_midfill_len", 32'(nfill), 32'd16);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 199) == 0));
        end

        // Grant totals: 10 A grants then 4 B grants after a reset.
        cycle(2'b00, 2'b00, '0, '0, 2'b00, 1'b0, 1'b1);
        count_fill(nfill);
        check("final_fill_len", 32'(nfill), 32'd16);
        for (int i = 0; i < 10; i++) cycle(2'b01, 2'b00, AW'(i), '0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(2'b10, 2'b01, '0, AW'(i), 2'b10, 1'b0, 1'b0);
        idle(1);
`ifdef BIT_ARRAY_CTRL_STATS_EN
        check("stat_grants_a", stat_grants_a, 32'd10);
        check("stat_grants_b", stat_grants_b, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
